// File: rtl/mcd_io_ctl_if.sv
// ============================================================================
// Module  : mcd_io_ctl_if
// Brief   : PI-bus side of the Mega-CD control/IO block (decode, write, readback)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface mcd_io_ctl_if;
  logic        ce_mcd;
  logic [15:0] addr;
  logic [7:0]  dato;
  logic        we_sync;
  logic [7:0]  dati;
  logic        ce_cdc;
  logic        ce_cdd;

  modport master (
    output ce_mcd, addr, dato, we_sync,
    input  dati, ce_cdc, ce_cdd
  );

  modport slave (
    input  ce_mcd, addr, dato, we_sync,
    output dati, ce_cdc, ce_cdd
  );
endinterface

`default_nettype wire

// File: rtl/mcd_io_ctl.sv
// ============================================================================
// Module  : mcd_io_ctl
// Brief   : Mega-CD control/IO registers, command pulses and CD-IRQ phase timer.
//           Optional readback path built when MCD_IO_RDBACK_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mcd_io_ctl #(
  parameter int CFG_BYTES = 8,
  parameter int CMD_BITS  = 4,
  parameter int PULSE_LEN = 1,
  parameter int PHA_W     = 12,
  parameter int PHA_DEF   = 350,
  parameter int CDC_LEN   = 2352,
  parameter int CDD_LEN   = 5
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  mcd_io_ctl_if.slave                    bus,
  input  wire logic                      sec_sync,
  input  wire logic                      pha_tick,
  output logic [CMD_BITS-1:0]            cmd_pulse,
  output logic                           irq_out,
  output logic [CFG_BYTES-1:0][7:0]      cfg_dsp,
  output logic [PHA_W-1:0]               cfg_pha,
  output logic                           pha_busy
);

  localparam logic [15:0]      c_cdc_len = 16'(CDC_LEN);
  localparam logic [15:0]      c_cdd_len = 16'(CDD_LEN);
  localparam logic [3:0]       c_pulse   = 4'(PULSE_LEN);
  localparam logic [PHA_W-1:0] c_pha_def = PHA_W'(PHA_DEF);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // ---------------- address decode ----------------
  logic w_cfg_sel;
  logic w_cfg_wr;
  logic w_cmd_wr;

  assign bus.ce_cdc = bus.ce_mcd && !bus.addr[15] && ({1'b0, bus.addr[14:0]} < c_cdc_len);
  assign bus.ce_cdd = bus.ce_mcd &&  bus.addr[15] && ({1'b0, bus.addr[14:0]} < c_cdd_len);

  assign w_cfg_sel = bus.ce_mcd && (bus.addr[15:8] == 8'hFF);
  assign w_cfg_wr  = bus.we_sync && w_cfg_sel;
  assign w_cmd_wr  = bus.we_sync && bus.ce_mcd && (bus.addr == 16'h8010);

  // ---------------- DSP config bytes ----------------
  logic [CFG_BYTES-1:0][7:0] r_dsp;

  for (genvar b = 0; b < CFG_BYTES; b++) begin : g_dsp
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_dsp[b] <= 8'h00;
      end else if (w_cfg_wr && (bus.addr[7:0] == 8'(b))) begin
        r_dsp[b] <= bus.dato;
      end
    end
  end

  assign cfg_dsp = r_dsp;

  // ---------------- phase register (high byte staged, low byte commits) ----------------
  logic [PHA_W-9:0] r_shadow;
  logic [PHA_W-1:0] r_pha;
  logic [PHA_W-1:0] w_pha_new;

  assign w_pha_new = {r_shadow, bus.dato};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= c_pha_def[PHA_W-1:8];
      r_pha    <= c_pha_def;
    end else if (w_cfg_wr) begin
      if (bus.addr[7:0] == 8'h80) begin
        r_shadow <= bus.dato[PHA_W-9:0];
      end else if (bus.addr[7:0] == 8'h81) begin
        r_pha <= (w_pha_new == '0) ? c_pha_def : w_pha_new;
      end
    end
  end

  assign cfg_pha = r_pha;

  // ---------------- stretched command pulses ----------------
  for (genvar i = 0; i < CMD_BITS; i++) begin : g_pulse
    logic [3:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= 4'd0;
      end else if (w_cmd_wr && bus.dato[i]) begin
        r_cnt <= c_pulse;
      end else if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end

    assign cmd_pulse[i] = (r_cnt != 4'd0);
  end

  // ---------------- phase timer ----------------
  logic [0:0]       r_state;
  logic [PHA_W-1:0] r_pcnt;
  logic             r_fire;

  // A sector sync always (re)loads, so a coincident tick is simply dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pcnt  <= '0;
      r_fire  <= 1'b0;
    end else begin
      r_fire <= 1'b0;
      if (sec_sync) begin
        r_state <= RUN;
        r_pcnt  <= r_pha;
      end else if ((r_state == RUN) && pha_tick) begin
        if (r_pcnt == PHA_W'(1)) begin
          r_fire  <= 1'b1;
          r_state <= IDLE;
          r_pcnt  <= '0;
        end else begin
          r_pcnt <= r_pcnt - PHA_W'(1);
        end
      end
    end
  end

  assign pha_busy = (r_state == RUN);
  assign irq_out  = cmd_pulse[0] | r_fire;

  // ---------------- readback ----------------
`ifdef MCD_IO_RDBACK_EN
  logic [7:0] w_rd;
  logic [7:0] r_dati;

  always_comb begin
    w_rd = 8'h00;
    if (w_cfg_sel) begin
      for (int b = 0; b < CFG_BYTES; b++) begin
        if (bus.addr[7:0] == 8'(b)) w_rd = r_dsp[b];
      end
      case (bus.addr[7:0])
        8'h80:   w_rd = 8'(r_pha >> 8);
        8'h81:   w_rd = r_pha[7:0];
        8'h82:   w_rd = {pha_busy, r_fire, 6'(cmd_pulse)};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_dati <= 8'h00;
    else     r_dati <= w_rd;
  end

  assign bus.dati = r_dati;
`else
  assign bus.dati = 8'h00;
`endif

endmodule

`default_nettype wire
